// File: rtl/sp_port_arbiter.sv
// rtl/sp_port_arbiter.sv - two-port round-robin arbiter in front of a 512x32 single-port RAM
//
// Purpose: zero-fills the RAM after reset (optional), then shares one
// single-port RAM between two request ports with round-robin arbitration
// and in-order read responses.
//
// Ports:
//   CLK, RESET            clock; asynchronous active-high reset
//   pX_valid/pX_ready     request handshake, grant is combinational
//   pX_we/addr/wdata/be   request payload (be used for writes only)
//   pX_rvalid/pX_rdata    read response, LAT = 1 + READ_PIPE cycles after accept
//   init_done             clear sequence finished, requests admitted
//   ram_*                 single-port RAM macro interface

module sp_port_arbiter #(
    parameter int READ_PIPE      = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic        p0_we,
    input  logic [8:0]  p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_be,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_we,
    input  logic [8:0]  p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_be,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        init_done,
    output logic        ram_ce,
    output logic        ram_wre,
    output logic        ram_oce,
    output logic        ram_reset,
    output logic [13:0] ram_ad,
    output logic [31:0] ram_di,
    output logic [2:0]  ram_blksel,
    input  logic [31:0] ram_do
);

    localparam int LAT = 1 + READ_PIPE;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [8:0]     r_cnt;
    logic [8:0]     w_cnt_nxt;
    logic           r_init_done;
    logic           r_last;          // 1: p1 was granted most recently
    logic [LAT-1:0] r_tag_v;
    logic [LAT-1:0] r_tag_id;        // 1: response belongs to p1
    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_sel_we;
    logic [8:0]     w_sel_addr;
    logic [31:0]    w_sel_wdata;
    logic [3:0]     w_sel_be;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_cnt       <= 9'd0;
            r_init_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Sticky: set on the edge that enters (or stays in) RUN.
            if (w_state_nxt == ST_RUN) begin
                r_init_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_last   <= 1'b1;
            r_tag_v  <= '0;
            r_tag_id <= '0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_last <= w_gnt1;
            end
            r_tag_v[0]  <= (w_gnt0 || w_gnt1) && !w_sel_we;
            r_tag_id[0] <= w_gnt1;
            for (int i = 1; i < LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        ram_ce      = 1'b0;
        ram_wre     = 1'b0;
        ram_ad      = 14'd0;
        ram_di      = 32'd0;
        case (r_state)
            ST_CLEAR: begin
                // Gated by RESET so the RAM sees no write while reset is held.
                ram_ce    = !RESET;
                ram_wre   = !RESET;
                ram_ad    = {r_cnt, 1'b0, 4'hF};
                w_cnt_nxt = r_cnt + 9'd1;
                if (r_cnt == 9'd511) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // r_init_done is low during reset and the first cycle after a
                // no-clear reset, which keeps the ports closed until then.
                if (r_init_done) begin
                    w_gnt0 = p0_valid && (!p1_valid || r_last);
                    w_gnt1 = p1_valid && (!p0_valid || !r_last);
                end
                if (w_gnt0 || w_gnt1) begin
                    ram_ce  = 1'b1;
                    ram_wre = w_sel_we;
                    ram_ad  = {w_sel_addr, 1'b0, (w_sel_we ? w_sel_be : 4'h0)};
                    ram_di  = w_sel_wdata;
                end
            end
            default: ;
        endcase
    end

    assign w_sel_we    = w_gnt1 ? p1_we    : p0_we;
    assign w_sel_addr  = w_gnt1 ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_gnt1 ? p1_wdata : p0_wdata;
    assign w_sel_be    = w_gnt1 ? p1_be    : p0_be;

    assign p0_ready   = w_gnt0;
    assign p1_ready   = w_gnt1;
    assign p0_rvalid  = r_tag_v[LAT-1] && !r_tag_id[LAT-1];
    assign p1_rvalid  = r_tag_v[LAT-1] &&  r_tag_id[LAT-1];
    assign p0_rdata   = ram_do;
    assign p1_rdata   = ram_do;
    assign init_done  = r_init_done;
    assign ram_oce    = 1'b1;
    assign ram_blksel = 3'b000;
    assign ram_reset  = RESET;

endmodule

// File: tb/tb_sp_port_arbiter.sv
// tb/tb_sp_port_arbiter.sv - self-checking bench for sp_port_arbiter

module tb_sp_port_arbiter;

    localparam int RP  = 0;
    localparam int LAT = 1 + RP;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        p0_valid, p0_ready, p0_we, p0_rvalid;
    logic [8:0]  p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic [3:0]  p0_be;
    logic        p1_valid, p1_ready, p1_we, p1_rvalid;
    logic [8:0]  p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic [3:0]  p1_be;
    logic        init_done;
    logic        ram_ce, ram_wre, ram_oce, ram_reset;
    logic [13:0] ram_ad;
    logic [31:0] ram_di, ram_do;
    logic [2:0]  ram_blksel;

    int checks   = 0;
    int failures = 0;

    sp_port_arbiter #(.READ_PIPE(RP), .CLEAR_ON_RESET(1)) dut (
        .CLK(CLK), .RESET(RESET),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_be(p0_be), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_be(p1_be), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .init_done(init_done),
        .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_oce(ram_oce), .ram_reset(ram_reset),
        .ram_ad(ram_ad), .ram_di(ram_di), .ram_blksel(ram_blksel), .ram_do(ram_do)
    );

    always #5 CLK = ~CLK;

    // RAM macro model: byte enables in ram_ad[3:0], word address in ram_ad[13:5].
    logic [31:0] ram_mem [512];
    logic [31:0] r_q, r_q2;
    always @(posedge CLK) begin
        if (ram_ce && ram_wre) begin
            for (int b = 0; b < 4; b++)
                if (ram_ad[b]) ram_mem[ram_ad[13:5]][8*b +: 8] <= ram_di[8*b +: 8];
        end
        if (ram_ce && !ram_wre) r_q <= ram_mem[ram_ad[13:5]];
        r_q2 <= r_q;
    end
    assign ram_do = (RP != 0) ? r_q2 : r_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected memory contents, clear progress, round-robin
    // owner and a queue of outstanding read responses with their due cycle.
    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } rsp_t;

    logic [31:0] m_mem [512];
    rsp_t        m_q[$];
    int          m_cyc   = 0;
    int          m_clr   = 0;
    int          m_last  = 1;
    int          rv0     = 0;
    int          rv1     = 0;

    always @(negedge CLK) begin
        int          g;
        logic        we;
        logic [8:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        e0, e1;
        logic [31:0] ed;
        rsp_t        r;
        m_cyc++;
        if (p0_rvalid) rv0++;
        if (p1_rvalid) rv1++;
        chk("ram_reset", 32'(ram_reset), 32'(RESET));
        chk("ram_oce", 32'(ram_oce), 32'd1);
        chk("ram_blksel", 32'(ram_blksel), 32'd0);
        if (RESET) begin
            chk("rst_ready", 32'({p0_ready, p1_ready}), 32'd0);
            chk("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
            chk("rst_ram_ce_wre", 32'({ram_ce, ram_wre}), 32'd0);
            chk("rst_init_done", 32'(init_done), 32'd0);
            m_q.delete();
            m_clr  = 0;
            m_last = 1;
        end else begin
            e0 = 1'b0; e1 = 1'b0; ed = 32'd0;
            if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
                r = m_q.pop_front();
                e0 = (r.port == 0);
                e1 = (r.port == 1);
                ed = r.data;
            end
            chk("p0_rvalid", 32'(p0_rvalid), 32'(e0));
            chk("p1_rvalid", 32'(p1_rvalid), 32'(e1));
            if (e0) chk("p0_rdata", p0_rdata, ed);
            if (e1) chk("p1_rdata", p1_rdata, ed);
            if (m_clr < 512) begin
                chk("clr_ready", 32'({p0_ready, p1_ready}), 32'd0);
                chk("clr_init_done", 32'(init_done), 32'd0);
                chk("clr_ce_wre", 32'({ram_ce, ram_wre}), 32'd3);
                chk("clr_ad", 32'(ram_ad), 32'({9'(m_clr), 1'b0, 4'hF}));
                chk("clr_di", ram_di, 32'd0);
                m_mem[m_clr] = 32'd0;
                m_clr++;
            end else begin
                chk("run_init_done", 32'(init_done), 32'd1);
                if (p0_valid && p1_valid) g = (m_last == 0) ? 1 : 0;
                else if (p0_valid)        g = 0;
                else if (p1_valid)        g = 1;
                else                      g = -1;
                chk("ready", 32'({p0_ready, p1_ready}), 32'({g == 0, g == 1}));
                if (g < 0) begin
                    chk("idle_ce_wre", 32'({ram_ce, ram_wre}), 32'd0);
                end else begin
                    we = (g == 1) ? p1_we    : p0_we;
                    a  = (g == 1) ? p1_addr  : p0_addr;
                    d  = (g == 1) ? p1_wdata : p0_wdata;
                    be = (g == 1) ? p1_be    : p0_be;
                    chk("gnt_ce", 32'(ram_ce), 32'd1);
                    chk("gnt_wre", 32'(ram_wre), 32'(we));
                    chk("gnt_ad", 32'(ram_ad), 32'({a, 1'b0, (we ? be : 4'h0)}));
                    chk("gnt_di", ram_di, d);
                    if (we) begin
                        for (int b = 0; b < 4; b++)
                            if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
                    end else begin
                        r.due = m_cyc + LAT; r.port = g; r.data = m_mem[a];
                        m_q.push_back(r);
                    end
                    m_last = g;
                end
            end
        end
    end

    task automatic idle();
        p0_valid = 1'b0; p0_we = 1'b0; p0_addr = 9'd0; p0_wdata = 32'd0; p0_be = 4'd0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_addr = 9'd0; p1_wdata = 32'd0; p1_be = 4'd0;
    endtask

    task automatic set_req(input int p, input logic we, input logic [8:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        if (p == 0) begin
            p0_valid = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; p0_be = be;
        end else begin
            p1_valid = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; p1_be = be;
        end
    endtask

    // One request; for reads returns the observed latency (0 = none) and data.
    task automatic do_op(input int p, input logic we, input logic [8:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         output int lat, output logic [31:0] rd);
        int n;
        @(posedge CLK); #1;
        idle();
        set_req(p, we, a, d, be);
        n = 0;
        @(negedge CLK);
        while (!((p == 1) ? p1_ready : p0_ready) && n < 20) begin
            n++;
            @(negedge CLK);
        end
        if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge CLK); #1;
        idle();
        lat = 0;
        rd  = 32'd0;
        if (!we) begin
            for (int k = 1; k <= 8; k++) begin
                @(negedge CLK);
                if ((p == 1) ? p1_rvalid : p0_rvalid) begin
                    lat = k;
                    rd  = (p == 1) ? p1_rdata : p0_rdata;
                    break;
                end
            end
        end
    endtask

    // Counts clear cycles after reset release while offering random reads.
    task automatic wait_init(output int n);
        n = 0;
        @(negedge CLK);
        chk("clear_start_ad", 32'(ram_ad), 32'h000F);
        while (!init_done && n < 600) begin
            n++;
            @(posedge CLK); #1;
            p0_valid = 1'($urandom_range(0, 1)); p0_we = 1'b0; p0_addr = 9'($urandom_range(0, 511));
            p1_valid = 1'($urandom_range(0, 1)); p1_we = 1'b0; p1_addr = 9'($urandom_range(0, 511));
            @(negedge CLK);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int          n, lat, b0, b1, g0, g1;
        logic        alt_ok, prev0;
        logic [31:0] rd;

        RESET = 1'b1;
        idle();
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        wait_init(n);
        chk("init_cycles", 32'(n), 32'd512);

        do_op(0, 1'b1, 9'd5, 32'hDEADBEEF, 4'hF, lat, rd);
        do_op(1, 1'b0, 9'd5, 32'd0, 4'h0, lat, rd);
        chk("raw_latency", 32'(lat), 32'(LAT));
        chk("raw_data", rd, 32'hDEADBEEF);

        @(posedge CLK); #1;
        idle();
        p0_valid = 1'b1; p1_valid = 1'b1;
        b0 = rv0; b1 = rv1; g0 = 0; g1 = 0; alt_ok = 1'b1; prev0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            p0_addr = 9'(20 + i);
            p1_addr = 9'(40 + i);
            @(negedge CLK);
            if (i == 0) chk("rr_first_p0", 32'(p0_ready), 32'd1);
            if (p0_ready == p1_ready) alt_ok = 1'b0;
            if (i > 0 && p0_ready == prev0) alt_ok = 1'b0;
            prev0 = p0_ready;
            g0 += int'(p0_ready);
            g1 += int'(p1_ready);
            @(posedge CLK); #1;
        end
        idle();
        repeat (4) @(negedge CLK);
        chk("rr_alternate", 32'(alt_ok), 32'd1);
        chk("rr_grants_p0", 32'(g0), 32'd4);
        chk("rr_grants_p1", 32'(g1), 32'd4);
        chk("rr_rvalid_p0", 32'(rv0 - b0), 32'd4);
        chk("rr_rvalid_p1", 32'(rv1 - b1), 32'd4);

        do_op(0, 1'b1, 9'd9, 32'h11223344, 4'hF, lat, rd);
        do_op(1, 1'b1, 9'd9, 32'hAABBCCDD, 4'b0010, lat, rd);
        do_op(0, 1'b0, 9'd9, 32'd0, 4'h0, lat, rd);
        chk("be_merge", rd, 32'h1122CC44);

        @(posedge CLK); #1;
        idle();
        set_req(0, 1'b0, 9'd9, 32'd0, 4'h0);
        @(negedge CLK);
        chk("rst_test_accept", 32'(p0_ready), 32'd1);
        @(posedge CLK); #1;
        RESET = 1'b1;
        idle();
        b0 = rv0;
        repeat (3) @(negedge CLK);
        chk("rst_no_rvalid", 32'(rv0 - b0), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        wait_init(n);
        chk("reinit_cycles", 32'(n), 32'd512);

        repeat (3000) begin
            @(posedge CLK); #1;
            p0_valid = ($urandom_range(0, 9) < 7);
            p0_we    = 1'($urandom_range(0, 1));
            p0_addr  = 9'($urandom_range(0, 15));
            p0_wdata = $urandom;
            p0_be    = 4'($urandom_range(0, 15));
            p1_valid = ($urandom_range(0, 9) < 7);
            p1_we    = 1'($urandom_range(0, 1));
            p1_addr  = 9'($urandom_range(0, 15));
            p1_wdata = $urandom;
            p1_be    = 4'($urandom_range(0, 15));
        end
        @(posedge CLK); #1;
        idle();
        repeat (6) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
